// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1-style TAP controller clocked by clk/ena.
// It has an IDCODE register, a USER data register and a bypass fallback for unknown opcodes.
module jtag_tap_param #(
  parameter int unsigned         IR_W         = 4,
  parameter int unsigned         USER_W       = 8,
  parameter logic [31:0]         IDCODE       = 32'h4BA0_0477,
  parameter logic [IR_W-1:0]     IDCODE_INSTR = 4'h1,
  parameter logic [IR_W-1:0]     USER_INSTR   = 4'h8,
  parameter logic [USER_W-1:0]   USER_RESET   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_oe,
  output logic [3:0]        state,
  output logic [IR_W-1:0]   ir_out,
  input  logic [USER_W-1:0] user_dr_in,
  output logic [USER_W-1:0] user_dr_out,
  output logic              user_update
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t cur, nxt;

  logic [IR_W-1:0]   ir_sr;
  logic [31:0]       id_sr;
  logic [USER_W-1:0] user_sr;
  logic              byp_sr;
  logic              sel_id, sel_user, to_tlr;

  assign sel_id   = (ir_out == IDCODE_INSTR);
  assign sel_user = (ir_out == USER_INSTR) && !sel_id;
  assign state    = cur;
  assign tdo_oe   = (cur == SH_DR) || (cur == SH_IR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cur <= TLR;
    else if (ena) cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PA_DR;
      PA_DR:  nxt = tms ? EX2_DR : PA_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PA_IR;
      PA_IR:  nxt = tms ? EX2_IR : PA_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

  // The TLR defaults are also applied on the edge that enters TLR,
  // so IDCODE is the active instruction as soon as TLR is reached.
  assign to_tlr = (cur == TLR) || (nxt == TLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_out      <= IDCODE_INSTR;
      user_dr_out <= USER_RESET;
      user_update <= 1'b0;
      ir_sr       <= '0;
      id_sr       <= '0;
      user_sr     <= '0;
      byp_sr      <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (ena) begin
        if (to_tlr) begin
          ir_out  <= IDCODE_INSTR;
          ir_sr   <= '0;
          id_sr   <= '0;
          user_sr <= '0;
          byp_sr  <= 1'b0;
        end else begin
          case (cur)
            CAP_IR: ir_sr <= IR_W'(2'b01);
            SH_IR:  ir_sr <= {tdi, ir_sr[IR_W-1:1]};
            UPD_IR: ir_out <= ir_sr;
            CAP_DR: begin
              if (sel_id)        id_sr   <= IDCODE;
              else if (sel_user) user_sr <= user_dr_in;
              else               byp_sr  <= 1'b0;
            end
            SH_DR: begin
              if (sel_id)        id_sr   <= {tdi, id_sr[31:1]};
              else if (sel_user) user_sr <= (user_sr >> 1) | (USER_W'(tdi) << (USER_W - 1));
              else               byp_sr  <= tdi;
            end
            UPD_DR: begin
              if (sel_user) begin
                user_dr_out <= user_sr;
                user_update <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (cur == SH_IR)      tdo = ir_sr[0];
    else if (cur == SH_DR) tdo = sel_id ? id_sr[0] : (sel_user ? user_sr[0] : byp_sr);
  end

endmodule
